stream_mux2_rr: RTL and testbench
=================================

// Module: stream_mux2_rr
// PURPOSE
//   2-to-1 merging multiplexer: return path for the 1-to-2 demultiplexer.
//   Merges two input streams, B and C, into one registered output stream using valid/ready handshakes.
//   Arbitrates round-robin between B and C.
//   Tags each output word with the source it came from (out_sel), so a downstream demultiplexer can split the stream again.
//   Sits between two producers and a single shared consumer link.
// PARAMETERS
//   DATA_W   2   width of every data lane (b_data, c_data, out_data)
// PORTS
//   clk        in   1       single clock; all state updates on rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   b_valid    in   1       lane B holds a word
//   b_data     in   DATA_W  lane B word
//   b_ready    out  1       lane B word accepted this cycle (b_valid & b_ready)
//   c_valid    in   1       lane C holds a word
//   c_data     in   DATA_W  lane C word
//   c_ready    out  1       lane C word accepted this cycle
//   out_valid  out  1       output register holds a word
//   out_data   out  DATA_W  output word
//   out_sel    out  1       source of out_data: 0 = B, 1 = C
//   out_ready  in   1       consumer takes the word (out_valid & out_ready)
// BEHAVIOUR
//   Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, last_grant=C.
//     The first contested grant therefore goes to B.
//   load_en = ~out_valid | out_ready  (register empty, or being drained this cycle).
//   Arbiter: 2-state FSM last_grant in {GNT_B, GNT_C}.
//     - Only b_valid  -> grant B.
//     - Only c_valid  -> grant C.
//     - Both valid    -> grant the lane opposite to last_grant.
//     - Neither valid -> no grant; last_grant unchanged.
//   Grant decision is combinational from the current-cycle valids and last_grant.
//   b_ready = load_en & grant==B;  c_ready = load_en & grant==C.
//     - Never both 1 in one cycle.
//     - Both 0 while the output is stalled.
//   On an accepted transfer (load_en & a grant):
//     - out_data <= granted data; out_sel <= granted lane; out_valid <= 1.
//     - last_grant <= granted lane.
//   On load_en with no grant: out_valid <= 0; out_data/out_sel keep their old values.
//   Stall (out_valid & ~out_ready): out_valid/out_data/out_sel stay frozen; no input is accepted.
//   Latency: 1 cycle from input acceptance to out_valid.
//   Throughput: 1 word/cycle when out_ready is held high (drain and load in the same cycle, no bubble).
//   Fairness: with both lanes continuously valid and out_ready=1, output order is B,C,B,C,...
//   Inputs are not registered. Producers must hold b_data/c_data stable while valid is high and ready is low.
//   Reset mid-transfer: a held word is discarded (out_valid->0), and the next contested grant goes to B.
//   No combinational path from out_* back to out_*; the ready outputs depend combinationally on out_ready.
// STRUCTURE
//   Shared package (mux_demux_pkg):
//     - localparams SEL_B=1'b0 and SEL_C=1'b1.
//     - Default DATA_W=2, also used by the demultiplexer.
//   One natural sub-module: rr_arb2. It holds the combinational grant logic and the last_grant flop,
//     and exposes req[1:0], advance, and gnt[1:0] (one-hot or zero).
//   The top level holds the output register and the ready generation.
// TESTING
//   1. Reset: rst_n=0 mid-run with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately.
//      After release, a contested grant goes to B.
//   2. Single lane: b_valid=1, b_data=2'b10, c_valid=0, out_ready=1 ->
//      next cycle out_valid=1, out_data=2'b10, out_sel=0; b_ready=1 each cycle.
//   3. Contention: both valid for 6 cycles, b_data=1, c_data=2, out_ready=1 ->
//      out_sel sequence 0,1,0,1,0,1; out_data 1,2,1,2,1,2; b_ready and c_ready never both 1.
//   4. Backpressure: word 2'b11 from C in the register, out_ready=0 for 3 cycles ->
//      out_data=2'b11, out_sel=1 held; b_ready=c_ready=0. When out_ready=1 -> a new word loads in the same cycle.
//   5. Drain to empty: single word, then both valids 0 with out_ready=1 ->
//      out_valid drops to 0 one cycle after the handshake; last_grant is kept for the next contest.
//   6. Loopback: connect to the demultiplexer with Select=out_sel ->
//      each word reappears on the lane it came from, across all 4 DATA_W=2 values on each lane.

Source files
------------

// File: rtl/mux_demux_pkg.sv
// ============================================================================
// mux_demux_pkg : lane-select encoding and defaults shared by the stream mux/demux pair
// Revision      : 1.0
// ============================================================================
`default_nettype none

package mux_demux_pkg;

  localparam int unsigned DATA_W_DEFAULT = 2;

  localparam logic SEL_B = 1'b0;
  localparam logic SEL_C = 1'b1;

  // Arbiter state reuses the lane encoding so last_grant maps directly onto out_sel.
  localparam logic [0:0] GNT_B = SEL_B;
  localparam logic [0:0] GNT_C = SEL_C;

  function automatic logic gnt_to_sel(input logic [1:0] gnt);
    return gnt[1] ? SEL_C : SEL_B;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_mux2_rr_if.sv
// ============================================================================
// stream_mux2_rr_if : two producer lanes (B, C) plus one tagged consumer link
// Revision          : 1.0
// ============================================================================
`default_nettype none

interface stream_mux2_rr_if
  import mux_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              c_valid;
  logic [DATA_W-1:0] c_data;
  logic              c_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sel;
  logic              out_ready;

  modport slave (
    input  b_valid, b_data, c_valid, c_data, out_ready,
    output b_ready, c_ready, out_valid, out_data, out_sel
  );

  modport master (
    output b_valid, b_data, c_valid, c_data, out_ready,
    input  b_ready, c_ready, out_valid, out_data, out_sel
  );

endinterface

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2  : two-requester round-robin arbiter, grant is combinational
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import mux_demux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,      // [0] = B, [1] = C
  input  logic       advance,  // grant is consumed this cycle
  output logic [1:0] gnt       // one-hot or zero
);

  logic [0:0] r_last_grant;
  logic [0:0] w_last_grant_nxt;

  // Resetting to C makes B the winner of the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GNT_C;
    end else begin
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_last_grant_nxt = r_last_grant;
    if (advance && (gnt != 2'b00)) begin
      w_last_grant_nxt = gnt_to_sel(gnt);
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_last_grant == GNT_C) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/stream_mux2_rr.sv
// ============================================================================
// stream_mux2_rr : round-robin 2:1 stream merge into a registered, source-tagged output
// Revision       : 1.0
// ============================================================================
`default_nettype none

module stream_mux2_rr
  import mux_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_mux2_rr_if.slave   bus
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sel;
  logic              w_load_en;
  logic [1:0]        w_gnt;

  // The register may load whenever it is empty or being drained this same cycle.
  assign w_load_en = ~r_out_valid | bus.out_ready;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.c_valid, bus.b_valid}),
    .advance (w_load_en),
    .gnt     (w_gnt)
  );

  assign bus.b_ready = w_load_en & w_gnt[0];
  assign bus.c_ready = w_load_en & w_gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= SEL_B;
    end else if (w_load_en) begin
      if (w_gnt != 2'b00) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt[1] ? bus.c_data : bus.b_data;
        r_out_sel   <= gnt_to_sel(w_gnt);
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux2_rr.sv
// ============================================================================
// tb_stream_mux2_rr : directed scenarios plus randomized traffic against a reference model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_stream_mux2_rr;
  import mux_demux_pkg::*;

  localparam int DW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_mux2_rr_if #(.DATA_W(DW)) bus ();

  stream_mux2_rr #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the output register should hold and which lane won last.
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_sel;
  logic          m_last;

  function automatic int ref_grant();
    if (bus.b_valid && bus.c_valid) return (m_last == SEL_C) ? 0 : 1;
    if (bus.b_valid) return 0;
    if (bus.c_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = SEL_B;
    m_last  = SEL_C;
  endtask

  // Advance model and DUT one clock using the inputs currently driven.
  task automatic tick();
    int   g;
    logic ld;
    ld = !m_valid || bus.out_ready;
    g  = ref_grant();
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_sel   = (g == 1);
        m_data  = (g == 1) ? bus.c_data : bus.b_data;
        m_last  = m_sel;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bv, input logic [DW-1:0] bd,
                       input logic cv, input logic [DW-1:0] cd, input logic ordy);
    bus.b_valid   = bv;
    bus.b_data    = bd;
    bus.c_valid   = cv;
    bus.c_data    = cd;
    bus.out_ready = ordy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 2'd0 || bus.out_sel !== 1'b0)
      $display("FAIL reset_init: got v=%b d=%0d s=%b exp v=0 d=0 s=0",
               bus.out_valid, bus.out_data, bus.out_sel);
    else n_pass++;

    rst_n = 1'b1;
    drive(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    #1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 2'd3 || bus.out_sel !== 1'b0)
      $display("FAIL reset_preload: got v=%b d=%0d s=%b exp v=1 d=3 s=0",
               bus.out_valid, bus.out_data, bus.out_sel);
    else n_pass++;

    // Assert reset between edges: the held word must vanish without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 2'd0 || bus.out_sel !== 1'b0)
      $display("FAIL reset_async: got v=%b d=%0d s=%b exp v=0 d=0 s=0",
               bus.out_valid, bus.out_data, bus.out_sel);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(1'b1, 2'd1, 1'b1, 2'd2, 1'b1);
    #1;
    n_checks++;
    if (bus.b_ready !== 1'b1 || bus.c_ready !== 1'b0)
      $display("FAIL reset_first_contest_ready: got b=%b c=%b exp b=1 c=0",
               bus.b_ready, bus.c_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_sel !== 1'b0 || bus.out_data !== 2'd1)
      $display("FAIL reset_first_contest_out: got s=%b d=%0d exp s=0 d=1",
               bus.out_sel, bus.out_data);
    else n_pass++;
  endtask

  task automatic test_single_lane();
    drive(1'b1, 2'b10, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.b_ready !== 1'b1 || bus.c_ready !== 1'b0)
        $display("FAIL single_ready[%0d]: got b=%b c=%b exp b=1 c=0", i, bus.b_ready, bus.c_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b10 || bus.out_sel !== 1'b0)
        $display("FAIL single_out[%0d]: got v=%b d=%0d s=%b exp v=1 d=2 s=0",
                 i, bus.out_valid, bus.out_data, bus.out_sel);
      else n_pass++;
    end
  endtask

  task automatic test_contention();
    // One C-only word leaves C as last winner, so the contest opens with B.
    drive(1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
    tick();
    drive(1'b1, 2'd1, 1'b1, 2'd2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      logic          exp_sel;
      logic [DW-1:0] exp_data;
      exp_sel  = (i % 2 == 1);
      exp_data = exp_sel ? 2'd2 : 2'd1;
      #1;
      n_checks++;
      if (bus.b_ready !== !exp_sel || bus.c_ready !== exp_sel)
        $display("FAIL contention_ready[%0d]: got b=%b c=%b exp b=%b c=%b",
                 i, bus.b_ready, bus.c_ready, !exp_sel, exp_sel);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== exp_sel || bus.out_data !== exp_data)
        $display("FAIL contention_out[%0d]: got v=%b s=%b d=%0d exp v=1 s=%b d=%0d",
                 i, bus.out_valid, bus.out_sel, bus.out_data, exp_sel, exp_data);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    drive(1'b0, 2'd0, 1'b1, 2'b11, 1'b1);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b11 || bus.out_sel !== 1'b1)
      $display("FAIL bp_load: got v=%b d=%0d s=%b exp v=1 d=3 s=1",
               bus.out_valid, bus.out_data, bus.out_sel);
    else n_pass++;
    drive(1'b1, 2'd0, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.b_ready !== 1'b0 || bus.c_ready !== 1'b0)
        $display("FAIL bp_ready[%0d]: got b=%b c=%b exp b=0 c=0", i, bus.b_ready, bus.c_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b11 || bus.out_sel !== 1'b1)
        $display("FAIL bp_hold[%0d]: got v=%b d=%0d s=%b exp v=1 d=3 s=1",
                 i, bus.out_valid, bus.out_data, bus.out_sel);
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.b_ready !== 1'b1 || bus.c_ready !== 1'b0)
      $display("FAIL bp_release_ready: got b=%b c=%b exp b=1 c=0", bus.b_ready, bus.c_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 2'd0 || bus.out_sel !== 1'b0)
      $display("FAIL bp_release_out: got v=%b d=%0d s=%b exp v=1 d=0 s=0",
               bus.out_valid, bus.out_data, bus.out_sel);
    else n_pass++;
  endtask

  task automatic test_drain();
    drive(1'b1, 2'd1, 1'b0, 2'd0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 2'd1 || bus.out_sel !== 1'b0)
      $display("FAIL drain_empty: got v=%b d=%0d s=%b exp v=0 d=1 s=0",
               bus.out_valid, bus.out_data, bus.out_sel);
    else n_pass++;
    drive(1'b1, 2'd2, 1'b1, 2'd3, 1'b1);
    #1;
    n_checks++;
    if (bus.b_ready !== 1'b0 || bus.c_ready !== 1'b1)
      $display("FAIL drain_kept_grant: got b=%b c=%b exp b=0 c=1", bus.b_ready, bus.c_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_sel !== 1'b1 || bus.out_data !== 2'd3)
      $display("FAIL drain_next_out: got s=%b d=%0d exp s=1 d=3", bus.out_sel, bus.out_data);
    else n_pass++;
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    tick();
  endtask

  // Random traffic; the consumer side acts as a demultiplexer steered by out_sel.
  task automatic test_random_loopback();
    logic [DW-1:0] q_lane[2][$];
    bit            seen[2][4];
    logic          hold_b = 1'b0;
    logic          hold_c = 1'b0;
    int            n_cycles = 400;
    for (int i = 0; i < n_cycles; i++) begin
      int   g;
      logic ld;
      logic exp_b_rdy;
      logic exp_c_rdy;
      if (i >= n_cycles - 4) begin
        drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
      end else begin
        if (!hold_b) begin
          bus.b_valid = ($urandom_range(0, 3) != 0);
          bus.b_data  = DW'($urandom_range(0, 3));
        end
        if (!hold_c) begin
          bus.c_valid = ($urandom_range(0, 3) != 0);
          bus.c_data  = DW'($urandom_range(0, 3));
        end
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      ld        = !m_valid || bus.out_ready;
      g         = ref_grant();
      exp_b_rdy = ld && (g == 0);
      exp_c_rdy = ld && (g == 1);
      n_checks++;
      if (bus.b_ready !== exp_b_rdy || bus.c_ready !== exp_c_rdy)
        $display("FAIL rand_ready[%0d]: got b=%b c=%b exp b=%b c=%b",
                 i, bus.b_ready, bus.c_ready, exp_b_rdy, exp_c_rdy);
      else n_pass++;
      n_checks++;
      if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_sel !== m_sel)
        $display("FAIL rand_out[%0d]: got v=%b d=%0d s=%b exp v=%b d=%0d s=%b",
                 i, bus.out_valid, bus.out_data, bus.out_sel, m_valid, m_data, m_sel);
      else n_pass++;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        int lane;
        lane = (bus.out_sel === 1'b1) ? 1 : 0;
        n_checks++;
        if (q_lane[lane].size() == 0) begin
          $display("FAIL loopback_extra[%0d]: got word %0d on lane %0d exp none", i, bus.out_data, lane);
        end else begin
          logic [DW-1:0] w;
          w = q_lane[lane].pop_front();
          if (bus.out_data !== w)
            $display("FAIL loopback_data[%0d]: got %0d on lane %0d exp %0d", i, bus.out_data, lane, w);
          else begin
            n_pass++;
            seen[lane][w] = 1'b1;
          end
        end
      end
      if (bus.b_valid && bus.b_ready === 1'b1) q_lane[0].push_back(bus.b_data);
      if (bus.c_valid && bus.c_ready === 1'b1) q_lane[1].push_back(bus.c_data);
      hold_b = bus.b_valid && (bus.b_ready !== 1'b1);
      hold_c = bus.c_valid && (bus.c_ready !== 1'b1);
      tick();
    end
    for (int lane = 0; lane < 2; lane++) begin
      int n_seen;
      n_seen = 0;
      for (int v = 0; v < 4; v++) if (seen[lane][v]) n_seen++;
      n_checks++;
      if (q_lane[lane].size() != 0 || n_seen != 4)
        $display("FAIL loopback_cover lane %0d: got pending=%0d values_seen=%0d exp pending=0 values_seen=4",
                 lane, q_lane[lane].size(), n_seen);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_contention();
    test_backpressure();
    test_drain();
    test_random_loopback();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
